sad_search_ctrl: RTL and testbench

//  Sequences a fixed-latency 16x16 SAD unit across an SR_X x SR_Y grid of candidate positions
//  in a block-matching motion search.
//  - Issues one candidate per cycle when the reference fetcher is ready.
//  - Counts SAD results as they return and tracks the minimum SAD and its (x,y).
//  - Sits between the search-window fetch logic and the SAD pipeline.

---
 rtl/sad_search_ctrl.sv | 138 +++++++++++++
 tb/tb_sad_search_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/sad_search_ctrl.sv
// Sequences a fixed-latency SAD unit over an SR_X x SR_Y candidate grid and tracks the minimum SAD.
// Issue follows ref_rdy combinationally; best_*/done update one cycle after the last result returns.
module sad_search_ctrl #(
  parameter int DWIDTH = 8,
  parameter int SR_X   = 8,
  parameter int SR_Y   = 8
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 ref_rdy,
  output logic                 cal_en,
  output logic [$clog2(SR_X)-1:0] cand_x,
  output logic [$clog2(SR_Y)-1:0] cand_y,
  input  logic [DWIDTH+7:0]    sad_in,
  input  logic                 sad_vld,
  output logic                 busy,
  output logic                 done,
  output logic [DWIDTH+7:0]    best_sad,
  output logic [$clog2(SR_X)-1:0] best_x,
  output logic [$clog2(SR_Y)-1:0] best_y
);

  localparam int XW = $clog2(SR_X);
  localparam int YW = $clog2(SR_Y);
  localparam int NC = SR_X * SR_Y;
  localparam int CW = $clog2(NC + 1);
  localparam int SW = DWIDTH + 8;
  localparam logic [CW-1:0] LAST_IDX = CW'(NC - 1);
  localparam logic [XW-1:0] LAST_X   = XW'(SR_X - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FLUSH} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   iss_cnt, ret_cnt, outstanding_nxt;
  logic [XW-1:0]   ptr_x;
  logic [YW-1:0]   ptr_y;
  logic [SW-1:0]   run_min;
  logic [XW-1:0]   run_x;
  logic [YW-1:0]   run_y;
  logic            searching, accept, consume, last_issue, last_ret, better, launch;
  logic [XW-1:0]   ret_x;
  logic [YW-1:0]   ret_y;

  assign cand_x    = ptr_x;
  assign cand_y    = ptr_y;
  assign busy      = (state != IDLE);
  assign searching = (state == ISSUE) || (state == DRAIN);
  assign launch    = (state == IDLE) && start && !abort;
  assign cal_en    = (state == ISSUE) && ref_rdy && !abort;
  assign accept    = searching && sad_vld;
  assign consume   = accept || ((state == FLUSH) && sad_vld);
  assign last_issue = cal_en && (iss_cnt == LAST_IDX);
  assign last_ret  = accept && !abort && (ret_cnt == LAST_IDX);
  assign better    = sad_in < run_min;
  // Returns arrive in issue order, so the return count is the candidate index.
  assign ret_x     = ret_cnt[XW-1:0];
  assign ret_y     = ret_cnt[XW +: YW];
  assign outstanding_nxt = iss_cnt - ret_cnt - {{(CW-1){1'b0}}, consume};

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (launch) state_nxt = ISSUE;
      ISSUE: begin
        if (abort)           state_nxt = (outstanding_nxt == '0) ? IDLE : FLUSH;
        else if (last_ret)   state_nxt = IDLE;
        else if (last_issue) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (abort)         state_nxt = (outstanding_nxt == '0) ? IDLE : FLUSH;
        else if (last_ret) state_nxt = IDLE;
      end
      FLUSH: if (outstanding_nxt == '0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      iss_cnt  <= '0;
      ret_cnt  <= '0;
      ptr_x    <= '0;
      ptr_y    <= '0;
      run_min  <= '1;
      run_x    <= '0;
      run_y    <= '0;
      done     <= 1'b0;
      best_sad <= '1;
      best_x   <= '0;
      best_y   <= '0;
    end else begin
      done <= 1'b0;
      if (launch) begin
        iss_cnt <= '0;
        ret_cnt <= '0;
        ptr_x   <= '0;
        ptr_y   <= '0;
        run_min <= '1;
        run_x   <= '0;
        run_y   <= '0;
      end else begin
        if (cal_en) begin
          iss_cnt <= iss_cnt + 1'b1;
          if (last_issue) begin
            ptr_x <= '0;
            ptr_y <= '0;
          end else if (ptr_x == LAST_X) begin
            ptr_x <= '0;
            ptr_y <= ptr_y + 1'b1;
          end else begin
            ptr_x <= ptr_x + 1'b1;
          end
        end
        if (consume) ret_cnt <= ret_cnt + 1'b1;
        // Strict compare keeps the earliest candidate on ties.
        if (accept && better) begin
          run_min <= sad_in;
          run_x   <= ret_x;
          run_y   <= ret_y;
        end
        if (last_ret) begin
          done     <= 1'b1;
          best_sad <= better ? sad_in : run_min;
          best_x   <= better ? ret_x  : run_x;
          best_y   <= better ? ret_y  : run_y;
        end
      end
    end
  end

endmodule

// File: tb/tb_sad_search_ctrl.sv
// Directed bench for sad_search_ctrl with a delay-line SAD unit model of selectable latency.
module tb_sad_search_ctrl;

  logic        clk = 1'b0;
  logic        rstn, start, abort, ref_rdy, sad_vld, cal_en, busy, done;
  logic [15:0] sad_in, best_sad;
  logic [2:0]  cand_x, cand_y, best_x, best_y;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [15:0] sad_tbl [64];
  int          lat = 9;
  int          iss_cnt = 0;
  int          ret_cnt = 0;
  logic        pv [16];
  logic [15:0] pd [16];

  sad_search_ctrl #(.DWIDTH(8), .SR_X(8), .SR_Y(8)) dut (
    .clk(clk), .rstn(rstn), .start(start), .abort(abort), .ref_rdy(ref_rdy),
    .cal_en(cal_en), .cand_x(cand_x), .cand_y(cand_y), .sad_in(sad_in),
    .sad_vld(sad_vld), .busy(busy), .done(done), .best_sad(best_sad),
    .best_x(best_x), .best_y(best_y)
  );

  always #5 clk = ~clk;

  // SAD unit model: result for the k-th issue of a search is sad_tbl[k], lat cycles later.
  always @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < 16; i++) begin
        pv[i] <= 1'b0;
        pd[i] <= '0;
      end
      iss_cnt <= 0;
      ret_cnt <= 0;
    end else begin
      pv[0] <= cal_en;
      pd[0] <= sad_tbl[iss_cnt % 64];
      for (int i = 1; i < 16; i++) begin
        pv[i] <= pv[i-1];
        pd[i] <= pd[i-1];
      end
      if (start && !busy) iss_cnt <= 0;
      else if (cal_en)    iss_cnt <= iss_cnt + 1;
      if (sad_vld) ret_cnt <= ret_cnt + 1;
    end
  end

  assign sad_vld = pv[lat-1];
  assign sad_in  = pd[lat-1];

  task automatic fill(input logic [15:0] base, input int ia, input logic [15:0] va,
                      input int ib, input logic [15:0] vb);
    for (int i = 0; i < 64; i++) sad_tbl[i] = base;
    if (ia >= 0) sad_tbl[ia] = va;
    if (ib >= 0) sad_tbl[ib] = vb;
  endtask

  // Called just after a negedge; returns at the negedge where done is seen (or on timeout).
  // cyc counts the start cycle as 1 and the done cycle inclusive.
  task automatic do_search(input int mode, input int extra_start, output int cyc,
                           output int pulses, output int cand_err, output bit got_done,
                           output logic [15:0] mid_sad, output logic [2:0] mid_x,
                           output logic [2:0] mid_y);
    start = 1'b1;
    ref_rdy = 1'b1;
    cyc = 1;
    cand_err = 0;
    got_done = 1'b0;
    mid_sad = '0; mid_x = '0; mid_y = '0;
    while (cyc < 400) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (done) begin
        got_done = 1'b1;
        break;
      end
      if (busy && iss_cnt < 64 &&
          (cand_x !== 3'(iss_cnt % 8) || cand_y !== 3'(iss_cnt / 8))) cand_err++;
      if (cyc == 30) begin
        mid_sad = best_sad; mid_x = best_x; mid_y = best_y;
      end
      ref_rdy = (mode == 1) ? (((cyc - 1) % 4 == 0) || ((cyc - 1) % 4 == 3)) : 1'b1;
      if (cyc == extra_start) start = 1'b1;
    end
    pulses = iss_cnt;
  endtask

  task automatic test_reset;
    rstn = 1'b0; start = 1'b0; abort = 1'b0; ref_rdy = 1'b0;
    fill(16'd100, -1, 0, -1, 0);
    repeat (3) @(negedge clk);
    n_cmp++; if (cal_en !== 1'b0) begin n_fail++; $display("FAIL reset_cal_en got %b exp 0", cal_en); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b exp 0", done); end
    n_cmp++; if (best_sad !== 16'hFFFF) begin n_fail++; $display("FAIL reset_best_sad got %h exp ffff", best_sad); end
    n_cmp++; if ({best_x, best_y} !== 6'd0) begin n_fail++; $display("FAIL reset_best_xy got %0d,%0d exp 0,0", best_x, best_y); end
    n_cmp++; if ({cand_x, cand_y} !== 6'd0) begin n_fail++; $display("FAIL reset_cand got %0d,%0d exp 0,0", cand_x, cand_y); end
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_full_search;
    int cyc, pulses, cerr; bit gd; logic [15:0] ms; logic [2:0] mx, my;
    lat = 9;
    fill(16'd100, 37, 16'd5, -1, 0);
    do_search(0, 0, cyc, pulses, cerr, gd, ms, mx, my);
    n_cmp++; if (gd !== 1'b1) begin n_fail++; $display("FAIL full_done got %b exp 1", gd); end
    n_cmp++; if (cyc != 75) begin n_fail++; $display("FAIL full_latency got %0d exp 75", cyc); end
    n_cmp++; if (pulses != 64) begin n_fail++; $display("FAIL full_pulses got %0d exp 64", pulses); end
    n_cmp++; if (cerr != 0) begin n_fail++; $display("FAIL full_cand_order got %0d errs exp 0", cerr); end
    n_cmp++; if (best_sad !== 16'd5) begin n_fail++; $display("FAIL full_best_sad got %0d exp 5", best_sad); end
    n_cmp++; if (best_x !== 3'd5 || best_y !== 3'd4) begin n_fail++; $display("FAIL full_best_xy got %0d,%0d exp 5,4", best_x, best_y); end
    @(negedge clk);
    n_cmp++; if (done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL full_done_pulse got done=%b busy=%b exp 0,0", done, busy); end
  endtask

  task automatic test_ties;
    int cyc, pulses, cerr; bit gd; logic [15:0] ms; logic [2:0] mx, my;
    fill(16'd42, -1, 0, -1, 0);
    do_search(0, 0, cyc, pulses, cerr, gd, ms, mx, my);
    n_cmp++; if (!gd || best_sad !== 16'd42 || best_x !== 3'd0 || best_y !== 3'd0) begin
      n_fail++; $display("FAIL ties_all42 got done=%b %0d@%0d,%0d exp 1 42@0,0", gd, best_sad, best_x, best_y); end
    @(negedge clk);
    fill(16'd42, 0, 16'd0, 63, 16'd0);
    do_search(0, 0, cyc, pulses, cerr, gd, ms, mx, my);
    n_cmp++; if (!gd || best_sad !== 16'd0 || best_x !== 3'd0 || best_y !== 3'd0) begin
      n_fail++; $display("FAIL ties_zero_first_last got done=%b %0d@%0d,%0d exp 1 0@0,0", gd, best_sad, best_x, best_y); end
    @(negedge clk);
  endtask

  task automatic test_ref_rdy_gaps;
    int cyc, pulses, cerr; bit gd; logic [15:0] ms; logic [2:0] mx, my;
    fill(16'd200, 50, 16'd3, -1, 0);
    do_search(1, 0, cyc, pulses, cerr, gd, ms, mx, my);
    n_cmp++; if (gd !== 1'b1) begin n_fail++; $display("FAIL gaps_done got %b exp 1", gd); end
    n_cmp++; if (pulses != 64) begin n_fail++; $display("FAIL gaps_pulses got %0d exp 64", pulses); end
    n_cmp++; if (cerr != 0) begin n_fail++; $display("FAIL gaps_cand_hold got %0d errs exp 0", cerr); end
    n_cmp++; if (best_sad !== 16'd3 || best_x !== 3'd2 || best_y !== 3'd6) begin
      n_fail++; $display("FAIL gaps_best got %0d@%0d,%0d exp 3@2,6", best_sad, best_x, best_y); end
    @(negedge clk);
  endtask

  task automatic test_abort;
    int r0; bit done_seen;
    lat = 9;
    fill(16'd1, -1, 0, -1, 0);
    r0 = ret_cnt;
    done_seen = 1'b0;
    start = 1'b1; ref_rdy = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    n_cmp++; if (iss_cnt != 20 || ret_cnt - r0 != 11) begin
      n_fail++; $display("FAIL abort_point got iss=%0d ret=%0d exp 20,11", iss_cnt, ret_cnt - r0); end
    abort = 1'b1;
    #1;
    n_cmp++; if (cal_en !== 1'b0) begin n_fail++; $display("FAIL abort_cal_en got %b exp 0", cal_en); end
    @(negedge clk);
    abort = 1'b0; ref_rdy = 1'b0;
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL abort_flush_busy got %b exp 1", busy); end
    for (int i = 0; i < 50 && busy; i++) begin
      @(negedge clk);
      if (done) done_seen = 1'b1;
    end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_to_idle got busy=%b exp 0", busy); end
    n_cmp++; if (done_seen || ret_cnt - r0 != 20 || iss_cnt != 20) begin
      n_fail++; $display("FAIL abort_flush got done_seen=%b ret=%0d iss=%0d exp 0,20,20", done_seen, ret_cnt - r0, iss_cnt); end
    n_cmp++; if (best_sad !== 16'd3 || best_x !== 3'd2 || best_y !== 3'd6) begin
      n_fail++; $display("FAIL abort_best_kept got %0d@%0d,%0d exp 3@2,6", best_sad, best_x, best_y); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int cyc, pulses, cerr; bit gd; logic [15:0] ms; logic [2:0] mx, my;
    lat = 9;
    fill(16'd100, 10, 16'd7, -1, 0);
    do_search(0, 10, cyc, pulses, cerr, gd, ms, mx, my);
    n_cmp++; if (!gd || cyc != 75 || pulses != 64) begin
      n_fail++; $display("FAIL busy_start_ignored got done=%b cyc=%0d pulses=%0d exp 1,75,64", gd, cyc, pulses); end
    n_cmp++; if (best_sad !== 16'd7 || best_x !== 3'd2 || best_y !== 3'd1) begin
      n_fail++; $display("FAIL busy_start_best got %0d@%0d,%0d exp 7@2,1", best_sad, best_x, best_y); end
    // New search launched in the done cycle, with a 1-cycle SAD unit and the minimum in the last slot.
    lat = 1;
    fill(16'd9, 63, 16'd1, -1, 0);
    do_search(0, 0, cyc, pulses, cerr, gd, ms, mx, my);
    n_cmp++; if (ms !== 16'd7 || mx !== 3'd2 || my !== 3'd1) begin
      n_fail++; $display("FAIL b2b_best_hold got %0d@%0d,%0d exp 7@2,1", ms, mx, my); end
    n_cmp++; if (!gd || cyc != 67 || pulses != 64 || cerr != 0) begin
      n_fail++; $display("FAIL b2b_run got done=%b cyc=%0d pulses=%0d cerr=%0d exp 1,67,64,0", gd, cyc, pulses, cerr); end
    n_cmp++; if (best_sad !== 16'd1 || best_x !== 3'd7 || best_y !== 3'd7) begin
      n_fail++; $display("FAIL b2b_best got %0d@%0d,%0d exp 1@7,7", best_sad, best_x, best_y); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_full_search();
    test_ties();
    test_ref_rdy_gaps();
    test_abort();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
